line_clear_ctrl: RTL and testbench
==================================

Name: line_clear_ctrl

Overview:
Sequences the post-lock line-clear phase of the playfield. After a piece locks, the block scans every board row through a row-wide read/write port and finds the lowest-index full row. It collapses that row by copying each row above it down by one, then rescans. This repeats until no full row remains, and the block then reports the number of lines cleared. It sits between the game FSM (start/done) and the board RAM, and owns the board port while busy.

Parameters:
ROWS, 23, number of board rows; row 0 is the top row.
COLS, 10, row width in cells.
CNT_W, 5, width of the lines-cleared counter.
SCORE_W, 20, width of the score accumulator (optional feature only).

Ports:
clk  in  1  system clock, all logic on the rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  one-cycle request to begin a clear pass; ignored unless the FSM is in IDLE
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a pass completes
lines_cleared  out  CNT_W  rows removed in the last pass; held until the next start
row_addr  out  $clog2(ROWS)  board row address
row_rd_data  in  COLS  read data, valid one cycle after row_addr
row_wr_en  out  1  write strobe
row_wr_data  out  COLS  write data
score  out  SCORE_W  accumulated score (feature only; otherwise 0)

Behaviour:
- Reset (rst_n=0 at an edge): FSM goes to IDLE. busy, done, row_wr_en, row_addr, row_wr_data, lines_cleared and score are all 0. A reset mid-pass abandons the pass immediately; board contents are left as they are with no repair, and no done pulse is issued.
- States: IDLE, SCAN, FIND, SHIFT_RD, SHIFT_WR, CLR_TOP, DONE.
- IDLE: on start=1, clear lines_cleared to 0 and go to SCAN.
- SCAN (ROWS+1 cycles): issue reads at row_addr 0..ROWS-1 on consecutive cycles. A row is full when row_rd_data is all ones; each row's full bit is captured into an internal full[ROWS-1:0] vector one cycle after its address is issued.
- FIND (1 cycle):
  - k = lowest index with full[k]=1.
  - If no row is full, go to DONE.
  - If k=0, go to CLR_TOP.
  - Otherwise set r=k and go to SHIFT_RD.
- SHIFT_RD: drive row_addr=r-1 with row_wr_en=0, then go to SHIFT_WR.
- SHIFT_WR:
  - Drive row_addr=r, row_wr_data=row_rd_data, row_wr_en=1.
  - Decrement r.
  - If the new r is 0, go to CLR_TOP; otherwise go to SHIFT_RD.
  - Result: rows 0..k-1 move down to rows 1..k.
- CLR_TOP (1 cycle):
  - Write row 0 with all zeros.
  - Increment lines_cleared, saturating at 2^CNT_W-1.
  - Go to SCAN, since a rescan is required because indices have moved.
- Cycle cost of clearing row k: 2k+1 cycles, followed by a full rescan.
- DONE (1 cycle): done=1, then return to IDLE. done is never asserted outside DONE.
- From start sampled to done high, with no full rows: exactly ROWS+3 cycles.
- row_wr_en is 1 only in SHIFT_WR and CLR_TOP. The block never writes while in IDLE, SCAN or FIND.
- start while busy=1 is ignored entirely: no restart and no queued request.
- start arriving in the same cycle as DONE is ignored. A new start is accepted only once the FSM is back in IDLE.

Optional Feature:
LINE_CLEAR_SCORE_EN
- Defined:
  - In DONE, add to score by lines_cleared of the pass: 0→0, 1→40, 2→100, 3→300, ≥4→1200.
  - The add saturates at 2^SCORE_W-1.
  - score resets to 0 only on rst_n.
- Undefined: no accumulator logic is built; score is tied to 0.

Test Plan:
Empty board, start pulse → no writes; done exactly 26 cycles after start (ROWS=23); lines_cleared=0; busy high for 25 cycles.
Row 22=0x3FF, row 21=0x0F0, all other rows 0; start → row 22 reads back 0x0F0, row 21 reads 0x000, row 0 reads 0x000; lines_cleared=1; score=40 with LINE_CLEAR_SCORE_EN.
Rows 19..22=0x3FF, row 18=0x155 → after the pass, row 22=0x155 and rows 0..21 are 0; lines_cleared=4; score=1200 with the feature.
Row 0=0x3FF only → exactly one write (row 0 ← 0); lines_cleared=1; no SHIFT_WR cycles.
Second start pulse asserted 5 cycles into a pass → ignored; exactly one done pulse; result identical to the single-start case.
rst_n low for 1 cycle during SHIFT_WR of a pass → next cycle busy=0, done=0, row_wr_en=0, lines_cleared=0; no done pulse follows; a fresh start then completes normally.

Source files
------------

// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: scans the board, collapses full rows one at a time and counts them; LINE_CLEAR_SCORE_EN adds a score accumulator.
module line_clear_ctrl #(
  parameter int ROWS = 23,
  parameter int COLS = 10,
  parameter int CNT_W = 5,
  parameter int SCORE_W = 20,
  localparam int AW = $clog2(ROWS),
  localparam int CW = $clog2(ROWS + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   lines_cleared,
  output logic [AW-1:0]      row_addr,
  input  logic [COLS-1:0]    row_rd_data,
  output logic               row_wr_en,
  output logic [COLS-1:0]    row_wr_data,
  output logic [SCORE_W-1:0] score
);
  localparam logic [2:0] IDLE = 3'd0, SCAN = 3'd1, FIND = 3'd2, SHIFT_RD = 3'd3,
                         SHIFT_WR = 3'd4, CLR_TOP = 3'd5, DONE = 3'd6;
  logic [2:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [AW-1:0]    r_row;
  logic [ROWS-1:0]  r_full;
  logic [CNT_W-1:0] r_lines;
  logic [AW-1:0]    w_k;
  logic [CW-1:0]    w_prev;
  assign w_prev = r_cnt - 1'b1;
  always_comb begin
    w_k = '0;
    for (int i = ROWS - 1; i >= 0; i--)
      if (r_full[i]) w_k = AW'(i);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_row   <= '0;
      r_full  <= '0;
      r_lines <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_lines <= '0;
          r_cnt   <= '0;
          r_state <= SCAN;
        end
        SCAN: begin
          // read data lags the address by one cycle, so slot cnt captures row cnt-1
          if (r_cnt != '0) r_full[w_prev] <= &row_rd_data;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(ROWS)) r_state <= FIND;
        end
        FIND: begin
          r_row   <= w_k;
          r_state <= ~|r_full ? DONE : (w_k == '0) ? CLR_TOP : SHIFT_RD;
        end
        SHIFT_RD: r_state <= SHIFT_WR;
        SHIFT_WR: begin
          r_row   <= r_row - 1'b1;
          r_state <= (r_row == AW'(1)) ? CLR_TOP : SHIFT_RD;
        end
        CLR_TOP: begin
          r_lines <= r_lines + (&r_lines ? CNT_W'(0) : CNT_W'(1));
          r_cnt   <= '0;
          r_state <= SCAN;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy          = r_state != IDLE;
  assign done          = r_state == DONE;
  assign lines_cleared = r_lines;
  assign row_wr_en     = (r_state == SHIFT_WR) || (r_state == CLR_TOP);
  assign row_wr_data   = (r_state == SHIFT_WR) ? row_rd_data : '0;
  assign row_addr      = (r_state == SCAN && r_cnt < CW'(ROWS)) ? r_cnt[AW-1:0] :
                         (r_state == SHIFT_RD) ? r_row - 1'b1 :
                         (r_state == SHIFT_WR) ? r_row : '0;
`ifdef LINE_CLEAR_SCORE_EN
  logic [SCORE_W-1:0] r_score;
  logic [SCORE_W-1:0] w_pts;
  logic [SCORE_W:0]   w_sum;
  assign w_pts = (r_lines == CNT_W'(0)) ? SCORE_W'(0) :
                 (r_lines == CNT_W'(1)) ? SCORE_W'(40) :
                 (r_lines == CNT_W'(2)) ? SCORE_W'(100) :
                 (r_lines == CNT_W'(3)) ? SCORE_W'(300) : SCORE_W'(1200);
  assign w_sum = {1'b0, r_score} + {1'b0, w_pts};
  always_ff @(posedge clk) begin
    if (!rst_n) r_score <= '0;
    else if (r_state == DONE) r_score <= w_sum[SCORE_W] ? '1 : w_sum[SCORE_W-1:0];
  end
  assign score = r_score;
`else
  assign score = '0;
`endif
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: directed bench for line_clear_ctrl with a board RAM model; honours LINE_CLEAR_SCORE_EN.
module tb_line_clear_ctrl;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic        busy, done, row_wr_en;
  logic [4:0]  lines_cleared, row_addr;
  logic [9:0]  row_rd_data = '0, row_wr_data;
  logic [19:0] score;
  logic [9:0]  mem [0:22];
  logic [9:0]  init_mem [0:22];
  logic        load = 0;
  int          wr_cnt = 0, done_cnt = 0;
  int          n_cmp = 0, n_err = 0;
  int          lat, bcyc, w0, d0, exp_score;
  logic [9:0]  acc;
`ifdef LINE_CLEAR_SCORE_EN
  localparam bit SC = 1;
`else
  localparam bit SC = 0;
`endif

  line_clear_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .lines_cleared(lines_cleared), .row_addr(row_addr), .row_rd_data(row_rd_data),
    .row_wr_en(row_wr_en), .row_wr_data(row_wr_data), .score(score)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (load) mem <= init_mem;
    else begin
      row_rd_data <= mem[row_addr];
      if (row_wr_en) mem[row_addr] <= row_wr_data;
    end
    if (row_wr_en) wr_cnt <= wr_cnt + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_board(input int r0, input logic [9:0] v0, input int r1, input logic [9:0] v1,
                            input int r2, input logic [9:0] v2);
    for (int i = 0; i < 23; i++) init_mem[i] = '0;
    if (r0 >= 0) init_mem[r0] = v0;
    if (r1 >= 0) init_mem[r1] = v1;
    if (r2 >= 0) init_mem[r2] = v2;
    @(negedge clk); load = 1;
    @(negedge clk); load = 0;
  endtask

  task automatic run_pass(input int restart_at, output int l, output int b);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    l = 1; b = 0;
    while (!done && l < 2000) begin
      if (busy) b++;
      start = (l == restart_at);
      @(negedge clk);
      l++;
    end
    start = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_en", row_wr_en, 0);
    chk("rst_addr", row_addr, 0);
    chk("rst_wr_data", row_wr_data, 0);
    chk("rst_lines", lines_cleared, 0);
    chk("rst_score", score, 0);
    rst_n = 1;
    exp_score = 0;

    load_board(-1, 0, -1, 0, -1, 0);
    w0 = wr_cnt;
    run_pass(0, lat, bcyc);
    chk("empty_latency", lat, 26);
    chk("empty_busy_before_done", bcyc, 25);
    chk("empty_busy_in_done", busy, 1);
    chk("empty_writes", wr_cnt - w0, 0);
    chk("empty_lines", lines_cleared, 0);
    chk("empty_score", score, 0);

    load_board(22, 10'h3FF, 21, 10'h0F0, -1, 0);
    w0 = wr_cnt;
    run_pass(0, lat, bcyc);
    exp_score += 40;
    chk("r22_latency", lat, 96);
    chk("r22_writes", wr_cnt - w0, 23);
    chk("r22_lines", lines_cleared, 1);
    @(negedge clk);
    chk("r22_row22", mem[22], 10'h0F0);
    chk("r22_row21", mem[21], 0);
    chk("r22_row0", mem[0], 0);
    chk("r22_score", score, SC ? exp_score : 0);

    for (int i = 0; i < 23; i++) init_mem[i] = (i >= 19) ? 10'h3FF : (i == 18) ? 10'h155 : 10'h000;
    @(negedge clk); load = 1;
    @(negedge clk); load = 0;
    w0 = wr_cnt;
    run_pass(0, lat, bcyc);
    exp_score += 1200;
    chk("quad_lines", lines_cleared, 4);
    chk("quad_writes", wr_cnt - w0, 86);
    @(negedge clk);
    chk("quad_row22", mem[22], 10'h155);
    acc = '0;
    for (int i = 0; i < 22; i++) acc = acc | mem[i];
    chk("quad_rows0_21", acc, 0);
    chk("quad_score", score, SC ? exp_score : 0);

    load_board(0, 10'h3FF, -1, 0, -1, 0);
    w0 = wr_cnt;
    run_pass(0, lat, bcyc);
    exp_score += 40;
    chk("top_latency", lat, 52);
    chk("top_writes", wr_cnt - w0, 1);
    chk("top_lines", lines_cleared, 1);
    @(negedge clk);
    chk("top_row0", mem[0], 0);
    chk("top_score", score, SC ? exp_score : 0);

    load_board(22, 10'h3FF, 21, 10'h0F0, -1, 0);
    w0 = wr_cnt;
    d0 = done_cnt;
    run_pass(5, lat, bcyc);
    exp_score += 40;
    chk("dbl_latency", lat, 96);
    repeat (120) @(negedge clk);
    chk("dbl_done_pulses", done_cnt - d0, 1);
    chk("dbl_idle", busy, 0);
    chk("dbl_writes", wr_cnt - w0, 23);
    chk("dbl_lines_held", lines_cleared, 1);
    chk("dbl_row22", mem[22], 10'h0F0);
    chk("dbl_score", score, SC ? exp_score : 0);

    load_board(22, 10'h3FF, 21, 10'h0F0, -1, 0);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (26) @(negedge clk);
    chk("mid_in_shift_wr", row_wr_en, 1);
    chk("mid_addr", row_addr, 22);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_wr_en", row_wr_en, 0);
    chk("mid_rst_lines", lines_cleared, 0);
    chk("mid_rst_score", score, 0);
    d0 = done_cnt;
    repeat (150) @(negedge clk);
    chk("mid_no_done", done_cnt - d0, 0);
    load_board(22, 10'h3FF, 21, 10'h0F0, -1, 0);
    run_pass(0, lat, bcyc);
    chk("fresh_latency", lat, 96);
    chk("fresh_lines", lines_cleared, 1);
    @(negedge clk);
    chk("fresh_row22", mem[22], 10'h0F0);
    chk("fresh_score", score, SC ? 40 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
